// File: rtl/matmul_load_sequencer.sv
// Load sequencer for one top_matmul job: fetches weight rows then input rows from two
// fixed-latency buffers, streams them gap-free to top_matmul, then waits for its done.
module matmul_load_sequencer #(
   parameter int unsigned WIDTH             = 16,
   parameter int unsigned I_OUTER_DIMENSION = 12,
   parameter int unsigned W_OUTER_DIMENSION = 6,
   parameter int unsigned INNER_DIMENSION   = 8,
   parameter int unsigned ADDR_WIDTH        = 10,
   parameter int unsigned W_BASE_ADDR       = 0,
   parameter int unsigned I_BASE_ADDR       = 0,
   parameter int unsigned RD_LATENCY        = 1,
   parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 ctrl_start,
   output logic                                 ctrl_busy,
   output logic                                 ctrl_done,
   output logic                                 ctrl_error,
   output logic                                 w_rd_en,
   output logic [ADDR_WIDTH-1:0]                w_rd_addr,
   input  logic [WIDTH*W_OUTER_DIMENSION-1:0]   w_rd_data,
   output logic                                 i_rd_en,
   output logic [ADDR_WIDTH-1:0]                i_rd_addr,
   input  logic [WIDTH*INNER_DIMENSION-1:0]     i_rd_data,
   output logic                                 en_top_matmul,
   output logic                                 input_w_valid,
   output logic [WIDTH*W_OUTER_DIMENSION-1:0]   input_w,
   output logic                                 input_i_valid,
   output logic [WIDTH*INNER_DIMENSION-1:0]     input_i,
   input  logic                                 out_matmul_done
);

   localparam int unsigned MAX_A   = (INNER_DIMENSION > I_OUTER_DIMENSION) ?
                                     INNER_DIMENSION : I_OUTER_DIMENSION;
   localparam int unsigned MAX_B   = (TIMEOUT_CYCLES > RD_LATENCY) ? TIMEOUT_CYCLES : RD_LATENCY;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_W    = 3'd1,
      LOAD_I    = 3'd2,
      DRAIN     = 3'd3,
      WAIT_DONE = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t                  state, state_nx;
   logic [CNT_W-1:0]        cnt, cnt_nx;
   logic                    error_nx;
   logic                    busy_nx, done_nx, en_nx, w_en_nx, i_en_nx;
   logic [ADDR_WIDTH-1:0]   w_addr_nx, i_addr_nx;
   logic [RD_LATENCY-1:0]   w_vld_sr, i_vld_sr;

   // Next-state, counter and next-output decode.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      error_nx = ctrl_error;
      case (state)
         IDLE: begin
            if (ctrl_start) begin
               state_nx = LOAD_W;
               cnt_nx   = '0;
               error_nx = 1'b0;
            end
         end
         LOAD_W: begin
            if (cnt == CNT_W'(INNER_DIMENSION - 1)) begin
               state_nx = LOAD_I;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         LOAD_I: begin
            if (cnt == CNT_W'(I_OUTER_DIMENSION - 1)) begin
               state_nx = DRAIN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DRAIN: begin
            // Hold until the last input row has left the read pipeline.
            if (cnt == CNT_W'(RD_LATENCY - 1)) begin
               state_nx = WAIT_DONE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (out_matmul_done) begin
               state_nx = DONE;
               cnt_nx   = '0;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               error_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      busy_nx   = (state_nx != IDLE);
      done_nx   = (state_nx == DONE);
      en_nx     = (state_nx == LOAD_W) || (state_nx == LOAD_I) ||
                  (state_nx == DRAIN)  || (state_nx == WAIT_DONE);
      w_en_nx   = (state_nx == LOAD_W);
      i_en_nx   = (state_nx == LOAD_I);
      w_addr_nx = w_en_nx ? ADDR_WIDTH'(W_BASE_ADDR) + ADDR_WIDTH'(cnt_nx) : '0;
      i_addr_nx = i_en_nx ? ADDR_WIDTH'(I_BASE_ADDR) + ADDR_WIDTH'(cnt_nx) : '0;
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         ctrl_busy     <= 1'b0;
         ctrl_done     <= 1'b0;
         ctrl_error    <= 1'b0;
         en_top_matmul <= 1'b0;
         w_rd_en       <= 1'b0;
         i_rd_en       <= 1'b0;
         w_rd_addr     <= '0;
         i_rd_addr     <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         ctrl_busy     <= busy_nx;
         ctrl_done     <= done_nx;
         ctrl_error    <= error_nx;
         en_top_matmul <= en_nx;
         w_rd_en       <= w_en_nx;
         i_rd_en       <= i_en_nx;
         w_rd_addr     <= w_addr_nx;
         i_rd_addr     <= i_addr_nx;
      end
   end

   if (RD_LATENCY == 1) begin : g_vld_one
      // Read strobes delayed one cycle to line up with buffer data.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            w_vld_sr <= '0;
            i_vld_sr <= '0;
         end else begin
            w_vld_sr <= w_rd_en;
            i_vld_sr <= i_rd_en;
         end
      end
   end else begin : g_vld_multi
      // Read strobes delayed RD_LATENCY cycles to line up with buffer data.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            w_vld_sr <= '0;
            i_vld_sr <= '0;
         end else begin
            w_vld_sr <= {w_vld_sr[RD_LATENCY-2:0], w_rd_en};
            i_vld_sr <= {i_vld_sr[RD_LATENCY-2:0], i_rd_en};
         end
      end
   end

   assign input_w_valid = w_vld_sr[RD_LATENCY-1];
   assign input_i_valid = i_vld_sr[RD_LATENCY-1];
   assign input_w       = w_rd_data;
   assign input_i       = i_rd_data;

endmodule
